// File: rtl/csa_seq_multiplier.sv
// Sequential unsigned multiplier: one 3:2 carry-save row reused per cycle,
// followed by a single carry-propagate add to resolve the redundant pair.
module csa_seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    COMPRESS,
    RESOLVE,
    DONE
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [PW-1:0]   sum;
  logic [PW-1:0]   carry;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   x;
  logic [PW-1:0]   y;
  logic [PW-1:0]   z;

  // Compressor inputs: running pair plus the current partial product row.
  always_comb begin
    x = sum;
    y = carry << 1;
    z = '0;
    if (b_reg[cnt]) begin
      z = {{WIDTH{1'b0}}, a_reg} << cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      product   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum       <= '0;
      carry     <= '0;
      cnt       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= a;
            b_reg    <= b;
            sum      <= '0;
            carry    <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= COMPRESS;
          end
        end
        COMPRESS: begin
          sum   <= x ^ y ^ z;
          carry <= (x & y) | (x & z) | (y & z);
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= RESOLVE;
          end
        end
        RESOLVE: begin
          // Carry MSB drop is harmless: the true product fits in PW bits.
          product   <= sum + (carry << 1);
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_seq_multiplier.sv
// Directed checks for csa_seq_multiplier at WIDTH=8 plus a WIDTH=32
// instance for full-scale and wide operand cases.
module tb_csa_seq_multiplier;

  localparam int W = 8;

  logic          clk = 0;
  logic          rst = 1;
  logic          in_valid = 0;
  logic          in_ready;
  logic [W-1:0]  a = 0;
  logic [W-1:0]  b = 0;
  logic          out_valid;
  logic          out_ready = 1;
  logic [2*W-1:0] product;
  logic          busy;

  logic          in_valid32 = 0;
  logic          in_ready32;
  logic [31:0]   a32 = 0;
  logic [31:0]   b32 = 0;
  logic          out_valid32;
  logic          out_ready32 = 1;
  logic [63:0]   product32;
  logic          busy32;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  csa_seq_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
  );

  csa_seq_multiplier #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32),
    .out_valid(out_valid32), .out_ready(out_ready32),
    .product(product32), .busy(busy32)
  );

  // Present operands until accepted; returns just after the accepting edge.
  task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit keep);
    bit rb;
    a = x;
    b = y;
    in_valid = 1;
    for (int i = 0; i < 100; i++) begin
      rb = in_ready;
      @(posedge clk);
      #1;
      if (rb) break;
    end
    if (!keep) in_valid = 0;
  endtask

  // Edges from acceptance until out_valid is seen; -1 on timeout.
  task automatic wait_done(output int cyc, output bit bz);
    cyc = -1;
    bz = 1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (!busy) bz = 0;
      if (out_valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    n_cmp++;
    if (product !== 16'h0) begin
      n_err++;
      $display("FAIL reset_product got %h want 0", product);
    end
  endtask

  task automatic test_basic;
    int cyc;
    bit bz;
    out_ready = 1;
    accept(8'd3, 8'd5, 0);
    wait_done(cyc, bz);
    n_cmp++;
    if (cyc !== W + 1) begin
      n_err++;
      $display("FAIL basic_latency got %0d want %0d", cyc, W + 1);
    end
    n_cmp++;
    if (product !== 16'd15) begin
      n_err++;
      $display("FAIL basic_product got %0d want 15", product);
    end
    n_cmp++;
    if (bz !== 1'b1) begin
      n_err++;
      $display("FAIL basic_busy got %b want 1", bz);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_return got rdy=%b vld=%b want 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_full_scale;
    int cyc;
    bit bz;
    accept(8'd255, 8'd255, 0);
    wait_done(cyc, bz);
    n_cmp++;
    if (cyc !== W + 1 || product !== 16'hFE01) begin
      n_err++;
      $display("FAIL full_scale got %h lat %0d want fe01 lat %0d",
               product, cyc, W + 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure;
    int cyc;
    bit bz;
    out_ready = 0;
    accept(8'd12, 8'd11, 0);
    wait_done(cyc, bz);
    n_cmp++;
    if (product !== 16'd132) begin
      n_err++;
      $display("FAIL bp_first got %0d want 132", product);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || product !== 16'd132) begin
        n_err++;
        $display("FAIL bp_hold cyc %0d got vld=%b p=%0d want 1 132",
                 i, out_valid, product);
      end
    end
    out_ready = 1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL bp_release got vld=%b rdy=%b busy=%b want 0 1 0",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic test_busy_input;
    int cyc;
    bit bz;
    bit rb;
    accept(8'd10, 8'd10, 0);
    repeat (3) @(posedge clk);
    #1;
    a = 8'd7;
    b = 8'd9;
    in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL busy_in_ready got %b want 0", in_ready);
    end
    wait_done(cyc, bz);
    n_cmp++;
    if (product !== 16'd100) begin
      n_err++;
      $display("FAIL busy_first got %0d want 100", product);
    end
    accept(8'd7, 8'd9, 0);
    wait_done(cyc, bz);
    n_cmp++;
    if (cyc !== W + 1 || product !== 16'd63) begin
      n_err++;
      $display("FAIL busy_second got %0d lat %0d want 63 lat %0d",
               product, cyc, W + 1);
    end
    rb = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    int cyc;
    bit bz;
    accept(8'd9, 8'd9, 0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        busy !== 1'b0 || product !== 16'd0) begin
      n_err++;
      $display("FAIL mid_reset got rdy=%b vld=%b busy=%b p=%0d want 1 0 0 0",
               in_ready, out_valid, busy, product);
    end
    accept(8'd6, 8'd7, 0);
    wait_done(cyc, bz);
    n_cmp++;
    if (cyc !== W + 1 || product !== 16'd42) begin
      n_err++;
      $display("FAIL mid_after got %0d lat %0d want 42 lat %0d",
               product, cyc, W + 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero_identity;
    int cyc;
    bit bz;
    accept(8'd0, 8'd200, 0);
    wait_done(cyc, bz);
    n_cmp++;
    if (cyc !== W + 1 || product !== 16'd0) begin
      n_err++;
      $display("FAIL zero got %0d lat %0d want 0 lat %0d",
               product, cyc, W + 1);
    end
    @(posedge clk);
    #1;
    accept(8'd1, 8'd200, 0);
    wait_done(cyc, bz);
    n_cmp++;
    if (cyc !== W + 1 || product !== 16'd200) begin
      n_err++;
      $display("FAIL identity got %0d lat %0d want 200 lat %0d",
               product, cyc, W + 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    int cyc;
    bit bz;
    logic [W-1:0]   va [4] = '{8'd13, 8'd128, 8'd2, 8'd99};
    logic [W-1:0]   vb [4] = '{8'd17, 8'd2, 8'd255, 8'd101};
    logic [2*W-1:0] ve [4] = '{16'd221, 16'd256, 16'd510, 16'd9999};
    for (int i = 0; i < 4; i++) begin
      accept(va[i], vb[i], 1);
      if (i < 3) begin
        a = va[i+1];
        b = vb[i+1];
      end
      wait_done(cyc, bz);
      n_cmp++;
      if (product !== ve[i]) begin
        n_err++;
        $display("FAIL b2b_%0d got %0d want %0d", i, product, ve[i]);
      end
    end
    in_valid = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random;
    int cyc;
    bit bz;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [2*W-1:0] e;
    for (int i = 0; i < 150; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      e = (2*W)'(x) * (2*W)'(y);
      accept(x, y, 0);
      wait_done(cyc, bz);
      n_cmp++;
      if (product !== e) begin
        n_err++;
        $display("FAIL rand %0d*%0d got %0d want %0d", x, y, product, e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_wide;
    int cyc;
    bit rb;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] e;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin
        x = 32'hFFFF_FFFF;
        y = 32'hFFFF_FFFF;
      end else begin
        x = $urandom;
        y = $urandom;
      end
      e = {32'h0, x} * {32'h0, y};
      a32 = x;
      b32 = y;
      in_valid32 = 1;
      for (int k = 0; k < 100; k++) begin
        rb = in_ready32;
        @(posedge clk);
        #1;
        if (rb) break;
      end
      in_valid32 = 0;
      cyc = -1;
      for (int k = 1; k <= 200; k++) begin
        @(posedge clk);
        #1;
        if (out_valid32) begin
          cyc = k;
          break;
        end
      end
      n_cmp++;
      if (cyc !== 33 || product32 !== e) begin
        n_err++;
        $display("FAIL wide_%0d got %h lat %0d want %h lat 33",
                 i, product32, cyc, e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_full_scale;
    test_backpressure;
    test_busy_input;
    test_reset_mid;
    test_zero_identity;
    test_back_to_back;
    test_random;
    test_wide;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/csa_seq_multiplier.md
Name: csa_seq_multiplier

Overview:
- Iterative unsigned multiplier built around a single shared 3:2 carry-save compressor stage (bitwise full adders, 2*WIDTH wide).
- A controller FSM feeds one partial product per cycle into the compressor, holding the redundant sum/carry pair in registers. It then resolves the pair with one carry-propagate add.
- This is the area-lean sequential alternative to the fully combinational Wallace tree. It uses a valid/ready handshake on both the operand and result sides.

Parameters:
- WIDTH, 32, operand width in bits. Product and internal compressor width = 2*WIDTH. Legal range 2..64.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands a, b present
- in_ready  output  1  block can accept operands
- a  input  WIDTH  multiplicand, unsigned
- b  input  WIDTH  multiplier, unsigned
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- product  output  2*WIDTH  a*b, unsigned
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst high at a clock edge): state=IDLE, in_ready=1, out_valid=0, busy=0, product=0. Internal sum, carry, count and operand registers are all cleared. Reset takes effect from any state; any in-flight operation is discarded with no output.
- FSM states: IDLE, COMPRESS, RESOLVE, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture a and b, clear sum, carry and cnt, then go to COMPRESS.
- COMPRESS:
  - in_ready=0.
  - Each cycle the compressor inputs are:
    - x = sum
    - y = (carry << 1) truncated to 2*WIDTH
    - z = b_reg[cnt] ? (a_reg << cnt) : 0, zero-extended to 2*WIDTH
  - Register updates: sum <= x^y^z; carry <= majority(x,y,z); cnt <= cnt+1.
  - When cnt == WIDTH-1 at the edge, go to RESOLVE. Exactly WIDTH compress cycles occur.
- RESOLVE:
  - product <= sum + (carry << 1), modulo 2^(2*WIDTH); go to DONE.
  - Dropping the carry MSB is safe because the true product is below 2^(2*WIDTH).
- DONE:
  - out_valid=1; product is held stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1: out_valid drops and the state goes to IDLE.
  - product keeps its last value after the handshake; it is not cleared.
- Latency:
  - Operands are accepted at edge E; out_valid is first high after edge E+WIDTH+1.
  - Minimum initiation interval is WIDTH+3 cycles (accept, WIDTH compress, resolve, output handshake, return to IDLE).
- in_valid while not in IDLE: ignored, and the operands are not captured. Upstream must hold them until in_ready.
- out_ready while not in DONE: ignored.
- a or b changing after acceptance has no effect on the result.
- Operands of zero still take the full latency; there is no early termination.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
- Basic timing (WIDTH=8): accept a=3, b=5 at edge E, out_ready held 1 → out_valid rises after edge E+9, product=15, busy high throughout, in_ready returns high one cycle after the result handshake.
- Full-scale operands (WIDTH=8): a=255, b=255 → product=0xFE01. With WIDTH=32, a=0xFFFFFFFF, b=0xFFFFFFFF → product=0xFFFFFFFE00000001. Check against a reference model for 10k random pairs at both widths.
- Backpressure: a=12, b=11, out_ready=0 for 20 cycles after out_valid → product stays 132 and out_valid stays 1 every cycle. Raising out_ready for one cycle completes the transfer and returns the FSM to IDLE.
- Busy-time input (WIDTH=8): new in_valid with a=7, b=9 pulsed during COMPRESS → ignored, in_ready=0, current result unaffected. The same operands held until in_ready=1 → accepted next, product=63.
- Reset mid-operation: rst asserted for one edge during COMPRESS (cnt=4) → next cycle state IDLE, in_ready=1, out_valid=0, product=0. A following a=6, b=7 yields 42 with normal latency.
- Zero and identity (WIDTH=8): a=0, b=200 → 0; a=1, b=200 → 200. Both take the full 9-cycle latency. Back-to-back transactions with in_valid held high give correct results in order.
